// File: rtl/uart_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// uart_sched_pkg : state encoding and width helper for the uart tx scheduler
// Revision: 1.0
// ============================================================================
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int max1(input int value);
        return (value > 1) ? value : 1;
    endfunction

endpackage : uart_sched_pkg
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// rr_pick : combinational round-robin picker with lock override
// Revision: 1.0
// ============================================================================
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int GW   = max1(clog2(NREQ))
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    input  logic            lock_en,
    input  logic [GW-1:0]   owner,
    output logic            found,
    output logic [GW-1:0]   index
);

    int            cand;
    logic [GW-1:0] cand_idx;

    always_comb begin
        found    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        if (lock_en) begin
            found = req[owner];
            index = owner;
        end else begin
            // Walk from the farthest offset down so the nearest hit after
            // last_grant is the final assignment.
            for (int k = NREQ; k >= 1; k--) begin
                cand     = (int'(last_grant) + k) % NREQ;
                cand_idx = GW'(cand);
                if (req[cand_idx]) begin
                    found = 1'b1;
                    index = cand_idx;
                end
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// uart_tx_scheduler : round-robin sharing of one uart transmitter among
// NREQ byte-stream requesters, with per-message locking and busy timeouts.
// Revision: 1.0
// ============================================================================
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int BUSY_TIMEOUT = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [8*NREQ-1:0]             req_data,
    input  logic [NREQ-1:0]               req_last,
    output logic [NREQ-1:0]               req_ready,
    output logic                          tx_start,
    output logic [7:0]                    tx_byte,
    input  logic                          tx_busy,
    output logic [max1(clog2(NREQ))-1:0]  grant_id,
    output logic                          active,
    output logic                          lock_held,
    output logic                          err_timeout
);

    localparam int GW     = max1(clog2(NREQ));
    localparam int BUSY_W = max1(clog2(BUSY_TIMEOUT));
    localparam int LOCK_W = max1(clog2(LOCK_TIMEOUT));

    localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(BUSY_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_LIMIT = LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [GW-1:0]     LAST_INIT  = GW'(NREQ - 1);

    sched_state_t      state, state_nxt;
    logic              tx_start_nxt;
    logic [7:0]        tx_byte_nxt;
    logic [GW-1:0]     grant_id_nxt;
    logic [GW-1:0]     last_grant, last_grant_nxt;
    logic              active_nxt;
    logic              lock_held_nxt;
    logic              err_timeout_nxt;
    logic              is_last, is_last_nxt;
    logic [BUSY_W-1:0] busy_cnt, busy_cnt_nxt;
    logic [LOCK_W-1:0] idle_cnt, idle_cnt_nxt;

    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic              accept;
    logic [7:0]        pick_data;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .lock_en    (lock_held),
        .owner      (grant_id),
        .found      (pick_found),
        .index      (pick_idx)
    );

    assign accept    = (state == IDLE) && pick_found && !tx_busy;
    assign pick_data = req_data[int'(pick_idx)*8 +: 8];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        tx_start_nxt    = tx_start;
        tx_byte_nxt     = tx_byte;
        grant_id_nxt    = grant_id;
        last_grant_nxt  = last_grant;
        active_nxt      = active;
        lock_held_nxt   = lock_held;
        err_timeout_nxt = 1'b0;
        is_last_nxt     = is_last;
        busy_cnt_nxt    = busy_cnt;
        idle_cnt_nxt    = idle_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    tx_byte_nxt    = pick_data;
                    tx_start_nxt   = 1'b1;
                    grant_id_nxt   = pick_idx;
                    last_grant_nxt = pick_idx;
                    active_nxt     = 1'b1;
                    is_last_nxt    = req_last[pick_idx];
                    busy_cnt_nxt   = '0;
                    idle_cnt_nxt   = '0;
                    state_nxt      = WAIT_BUSY;
                end else if (lock_held && !req_valid[grant_id]) begin
                    // Owner went quiet: release the lock after a bounded wait.
                    if (idle_cnt == LOCK_LIMIT) begin
                        lock_held_nxt = 1'b0;
                        idle_cnt_nxt  = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end
            end

            WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_nxt = 1'b0;
                    state_nxt    = WAIT_DONE;
                end else if (busy_cnt == BUSY_LIMIT) begin
                    err_timeout_nxt = 1'b1;
                    tx_start_nxt    = 1'b0;
                    active_nxt      = 1'b0;
                    lock_held_nxt   = 1'b0;
                    idle_cnt_nxt    = '0;
                    state_nxt       = IDLE;
                end else begin
                    busy_cnt_nxt = busy_cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (!tx_busy) begin
                    active_nxt    = 1'b0;
                    lock_held_nxt = !is_last;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                tx_start_nxt  = 1'b0;
                active_nxt    = 1'b0;
                lock_held_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_byte     <= 8'h00;
            grant_id    <= '0;
            last_grant  <= LAST_INIT;
            active      <= 1'b0;
            lock_held   <= 1'b0;
            err_timeout <= 1'b0;
            is_last     <= 1'b0;
            busy_cnt    <= '0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            tx_start    <= tx_start_nxt;
            tx_byte     <= tx_byte_nxt;
            grant_id    <= grant_id_nxt;
            last_grant  <= last_grant_nxt;
            active      <= active_nxt;
            lock_held   <= lock_held_nxt;
            err_timeout <= err_timeout_nxt;
            is_last     <= is_last_nxt;
            busy_cnt    <= busy_cnt_nxt;
            idle_cnt    <= idle_cnt_nxt;
        end
    end

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_uart_tx_scheduler : randomized message traffic against a message-level
// round-robin reference, plus lock-timeout, busy-timeout and reset cases.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int NREQ         = 3;
    localparam int BUSY_TIMEOUT = 16;
    localparam int LOCK_TIMEOUT = 64;
    localparam int GW           = 2;
    localparam int FRAME        = 40;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid;
    logic [8*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_start;
    logic [7:0]           tx_byte;
    logic                 tx_busy;
    logic [GW-1:0]        grant_id;
    logic                 active;
    logic                 lock_held;
    logic                 err_timeout;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ         (NREQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .lock_held   (lock_held),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [GW-1:0] id;
        logic [7:0]    data;
        logic          lock;
    } exp_t;

    beat_t drv_q [NREQ][$];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    logic  stuck = 1'b0;
    int    model_last = NREQ - 1;
    logic  model_prev_last = 1'b1;

    // Transceiver stand-in: 2-flop edge detect on tx_start, busy for FRAME cycles.
    logic       s1, s2, s3, cap_pulse;
    logic [7:0] cap_byte;
    int         fcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            tx_busy <= 1'b0; fcnt <= 0; cap_pulse <= 1'b0; cap_byte <= 8'h00;
        end else begin
            s1 <= tx_start; s2 <= s1; s3 <= s2;
            cap_pulse <= 1'b0;
            if (tx_busy) begin
                if (fcnt <= 1) tx_busy <= 1'b0;
                fcnt <= fcnt - 1;
            end else if (s2 && !s3 && !stuck) begin
                tx_busy   <= 1'b1;
                fcnt      <= FRAME;
                cap_byte  <= tx_byte;
                cap_pulse <= 1'b1;
            end
        end
    end

    // Requester driver: presents queue heads, advances on an accepted byte.
    initial begin
        logic [NREQ-1:0] rdy;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!reset && rdy[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = drv_q[i][0].data;
                    req_last[i]        = drv_q[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard compare on each byte the transceiver takes.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (req_ready != '0) begin
                checks++;
                if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
                    errors++;
                    $display("FAIL ready_onehot ready=%b valid=%b required one valid bit", req_ready, req_valid);
                end
            end
            if (cap_pulse) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got=%h required none", cap_byte);
                end else begin
                    e = sb.pop_front();
                    if (cap_byte !== e.data || grant_id !== e.id || lock_held !== e.lock || active !== 1'b1) begin
                        errors++;
                        $display("FAIL tx_frame got byte=%h id=%0d lock=%b active=%b required byte=%h id=%0d lock=%b active=1",
                                 cap_byte, grant_id, lock_held, active, e.data, e.id, e.lock);
                    end
                end
            end
        end
    end

    task automatic check(input logic ok, input string name, input int got, input int want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_last      = NREQ - 1;
        model_prev_last = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int  n;
        logic pend;
        n = 0;
        forever begin
            pend = (sb.size() != 0) || active || tx_busy;
            for (int i = 0; i < NREQ; i++) if (drv_q[i].size() != 0) pend = 1'b1;
            if (!pend || n >= budget) break;
            @(negedge clk);
            n++;
        end
        check(n < budget, name, n, budget);
    endtask

    task automatic push_beat(input int r, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        drv_q[r].push_back(b);
    endtask

    task automatic push_exp(input int r, input logic [7:0] d, input logic l);
        exp_t e;
        e.id = GW'(r);
        e.data = d;
        e.lock = l;
        sb.push_back(e);
    endtask

    // Random message mix; expected order from message-level round robin.
    task automatic run_phase();
        beat_t mq [NREQ][$];
        beat_t wq [NREQ][$];
        beat_t b;
        int    total, nmsg, len, found, c;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            nmsg = $urandom_range(0, 2);
            for (int m = 0; m < nmsg; m++) begin
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) begin
                    b.data = 8'($urandom);
                    b.last = (j == len - 1);
                    mq[i].push_back(b);
                    total++;
                end
            end
        end
        if (total == 0) begin
            b.data = 8'($urandom);
            b.last = 1'b1;
            mq[$urandom_range(0, NREQ - 1)].push_back(b);
        end
        for (int i = 0; i < NREQ; i++) wq[i] = mq[i];
        forever begin
            found = -1;
            for (int k = 1; k <= NREQ; k++) begin
                c = (model_last + k) % NREQ;
                if (found < 0 && wq[c].size() > 0) found = c;
            end
            if (found < 0) break;
            do begin
                b = wq[found].pop_front();
                push_exp(found, b.data, !model_prev_last);
                model_prev_last = b.last;
            end while (!b.last);
            model_last = found;
        end
        for (int i = 0; i < NREQ; i++)
            foreach (mq[i][j]) drv_q[i].push_back(mq[i][j]);
        wait_idle(6000, "phase_drain");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic saw;

        repeat (2) @(negedge clk);
        check(tx_start == 0 && tx_byte == 0 && grant_id == 0 && active == 0 &&
              lock_held == 0 && err_timeout == 0 && req_ready == 0,
              "reset_state", {tx_start, active, lock_held, err_timeout}, 0);
        do_reset();

        repeat (8) run_phase();

        // Lock held by requester 2, then abandoned: lock drops after LOCK_TIMEOUT idle cycles.
        do_reset();
        push_beat(2, 8'h5A, 1'b0);
        push_exp(2, 8'h5A, 1'b0);
        wait_idle(500, "lock_frame_drain");
        check(lock_held == 1'b1, "lock_set", lock_held, 1);
        push_beat(0, 8'hC3, 1'b1);
        push_exp(0, 8'hC3, 1'b0);
        n = 0;
        saw = 1'b0;
        while (lock_held && n < 200) begin
            @(negedge clk);
            n++;
            if (lock_held && req_ready != '0) saw = 1'b1;
        end
        check(n == LOCK_TIMEOUT, "lock_timeout_cycles", n, LOCK_TIMEOUT);
        check(!saw, "no_grant_while_locked", saw, 0);
        wait_idle(500, "after_lock_drain");

        // tx_busy never rises: timeout pulse, byte dropped, next request served.
        do_reset();
        stuck = 1'b1;
        push_beat(1, 8'h99, 1'b1);
        n = 0;
        while (!tx_start && n < 100) begin @(negedge clk); n++; end
        check(tx_start == 1'b1, "tx_start_rise", tx_start, 1);
        n = 0;
        while (!err_timeout && n < 100) begin @(negedge clk); n++; end
        check(n == BUSY_TIMEOUT, "busy_timeout_cycles", n, BUSY_TIMEOUT);
        check(tx_start == 0 && active == 0 && lock_held == 0, "timeout_outputs",
              {tx_start, active, lock_held}, 0);
        @(negedge clk);
        check(err_timeout == 1'b0, "err_pulse_width", err_timeout, 0);
        stuck = 1'b0;
        push_beat(1, 8'h42, 1'b1);
        push_exp(1, 8'h42, 1'b0);
        wait_idle(500, "after_timeout_drain");

        // Reset mid-frame while the lock is held.
        do_reset();
        push_beat(0, 8'h3B, 1'b0);
        push_beat(0, 8'h3C, 1'b0);
        push_exp(0, 8'h3B, 1'b0);
        push_exp(0, 8'h3C, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
        check(sb.size() == 0, "midframe_reach", sb.size(), 0);
        repeat (10) @(negedge clk);
        check(active == 1'b1 && tx_busy == 1'b1, "midframe_busy", {active, tx_busy}, 3);
        #2;
        reset = 1'b1;
        #1;
        check(tx_start == 0 && active == 0 && lock_held == 0, "async_reset_outputs",
              {tx_start, active, lock_held}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last      = NREQ - 1;
        model_prev_last = 1'b1;
        push_beat(1, 8'h7E, 1'b1);
        push_exp(1, 8'h7E, 1'b0);
        wait_idle(500, "after_reset_drain");
        check(lock_held == 1'b0, "final_no_lock", lock_held, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_scheduler
`default_nettype wire
